// File: rtl/vector_cpu_ifidexemem_core.sv
// ---------------------------------------------------------------------------
// vector_cpu_ifidexemem_core
//
// Four-stage (IF / ID / EX / MEM) 4-lane x 32-bit vector processor.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   we_pxl, wr_pos_pxl,      external write of {wdp1..wdp4} into pixel bank
//   wdp1..wdp4                 entry P[wr_pos_pxl]
//   we_mul, wr_mul_pos_in,   external write of {wdm1..wdm4} into mul bank
//   wdm1..wdm4                 entry M[wr_mul_pos_in]
//   instr_out                IF/ID instruction register
//   wr_pxl, wr_pos,          ID/EX control bits
//   wr_mul_reg, alu_func,
//   wr_wom, wr_mul_pos_out
//   pix_out1..4, cte_out1..4 ID/EX operand lanes
//   wom_addr                 ID/EX store address (i*n+j)
//   mul_out1..8              live view of M[0] (1..4) and M[1] (5..8)
//   i, j, n                  scalar registers
//   r1..r4                   EX/MEM ALU result lanes
//   load1..4                 MEM/WB output-memory read lanes
//   sumr1..4                 MEM/WB running lane sums
//
// Instruction ROM: 32 words supplied through ROM_IMAGE (word k occupies
// bits [32*k+31 : 32*k]); the image is generated from vector_prog.hex.
// Unlisted words are zero, which decodes as NOP.
//
// Optional feature: define SUMR_ACC_EN to build the per-lane accumulator
// that adds every VADD/VMUL result reaching MEM into sumr1..4. Without it
// sumr1..4 are tied to zero.
// ---------------------------------------------------------------------------
module vector_cpu_ifidexemem_core #(
  parameter logic [1023:0] ROM_IMAGE = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_pos_pxl,
  input  logic        we_pxl,
  input  logic        we_mul,
  input  logic [31:0] wdp1,
  input  logic [31:0] wdp2,
  input  logic [31:0] wdp3,
  input  logic [31:0] wdp4,
  input  logic [31:0] wdm1,
  input  logic [31:0] wdm2,
  input  logic [31:0] wdm3,
  input  logic [31:0] wdm4,
  input  logic        wr_mul_pos_in,
  output logic [31:0] instr_out,
  output logic        wr_pxl,
  output logic        wr_pos,
  output logic        wr_mul_reg,
  output logic        alu_func,
  output logic        wr_wom,
  output logic        wr_mul_pos_out,
  output logic [31:0] pix_out1,
  output logic [31:0] pix_out2,
  output logic [31:0] pix_out3,
  output logic [31:0] pix_out4,
  output logic [31:0] cte_out1,
  output logic [31:0] cte_out2,
  output logic [31:0] cte_out3,
  output logic [31:0] cte_out4,
  output logic [31:0] mul_out1,
  output logic [31:0] mul_out2,
  output logic [31:0] mul_out3,
  output logic [31:0] mul_out4,
  output logic [31:0] mul_out5,
  output logic [31:0] mul_out6,
  output logic [31:0] mul_out7,
  output logic [31:0] mul_out8,
  output logic [31:0] i,
  output logic [31:0] j,
  output logic [31:0] n,
  output logic [31:0] wom_addr,
  output logic [31:0] r1,
  output logic [31:0] r2,
  output logic [31:0] r3,
  output logic [31:0] r4,
  output logic [31:0] load1,
  output logic [31:0] load2,
  output logic [31:0] load3,
  output logic [31:0] load4,
  output logic [31:0] sumr1,
  output logic [31:0] sumr2,
  output logic [31:0] sumr3,
  output logic [31:0] sumr4
);

  // Lane 1 lives in element [0].
  typedef logic [3:0][31:0] vec_t;

  localparam logic [3:0] OP_VADD = 4'd1;
  localparam logic [3:0] OP_VMUL = 4'd2;
  localparam logic [3:0] OP_SETI = 4'd3;

  // Architectural state
  logic [4:0]  pc_q, pc_d;
  logic [31:0] ifid_q, ifid_d;
  logic [31:0] i_q, i_d, j_q, j_d, n_q, n_d;
  vec_t        p_q [2];
  vec_t        p_d [2];
  vec_t        m_q [2];
  vec_t        m_d [2];
  vec_t        wom_q [16];
  vec_t        wom_d [16];

  // ID/EX
  logic        idex_wr_pxl_q, idex_wr_pxl_d;
  logic        idex_wr_pos_q, idex_wr_pos_d;
  logic        idex_wr_mul_reg_q, idex_wr_mul_reg_d;
  logic        idex_wr_mul_pos_q, idex_wr_mul_pos_d;
  logic        idex_wr_wom_q, idex_wr_wom_d;
  logic        idex_alu_func_q, idex_alu_func_d;
  vec_t        idex_pix_q, idex_pix_d;
  vec_t        idex_cte_q, idex_cte_d;
  logic [31:0] idex_addr_q, idex_addr_d;

  // EX/MEM
  logic        exmem_wr_pxl_q, exmem_wr_pxl_d;
  logic        exmem_wr_pos_q, exmem_wr_pos_d;
  logic        exmem_wr_mul_reg_q, exmem_wr_mul_reg_d;
  logic        exmem_wr_mul_pos_q, exmem_wr_mul_pos_d;
  logic        exmem_wr_wom_q, exmem_wr_wom_d;
  vec_t        exmem_r_q, exmem_r_d;
  logic [31:0] exmem_addr_q, exmem_addr_d;

  // MEM/WB
  vec_t        memwb_load_q, memwb_load_d;

`ifdef SUMR_ACC_EN
  // A VADD with no write bits has all-zero controls like a NOP, so the
  // accumulator needs its own "vector op in this stage" marker.
  logic        idex_vec_q, idex_vec_d;
  logic        exmem_vec_q, exmem_vec_d;
  vec_t        sumr_q, sumr_d;
`endif

  // ID decode
  logic [3:0]  id_op;
  logic        id_is_vec;
  logic        id_is_seti;
  logic [1:0]  id_ssel;
  logic [31:0] id_imm;
  vec_t        wdp_v, wdm_v;

  assign wdp_v = {wdp4, wdp3, wdp2, wdp1};
  assign wdm_v = {wdm4, wdm3, wdm2, wdm1};

  always_comb begin
    id_op      = ifid_q[31:28];
    id_is_vec  = (id_op == OP_VADD) || (id_op == OP_VMUL);
    id_is_seti = (id_op == OP_SETI);
    id_ssel    = ifid_q[25:24];
    id_imm     = {16'h0000, ifid_q[15:0]};
  end

  always_comb begin
    // ---------------- IF ----------------
    pc_d   = pc_q + 5'd1;
    ifid_d = ROM_IMAGE[{pc_q, 5'd0} +: 32];

    // ---------------- ID ----------------
    // Non-vector opcodes (NOP, SETI, 4..15) leave the ID/EX register empty.
    idex_wr_pxl_d     = 1'b0;
    idex_wr_pos_d     = 1'b0;
    idex_wr_mul_reg_d = 1'b0;
    idex_wr_mul_pos_d = 1'b0;
    idex_wr_wom_d     = 1'b0;
    idex_alu_func_d   = 1'b0;
    idex_pix_d        = '0;
    idex_cte_d        = '0;
    idex_addr_d       = '0;
    if (id_is_vec) begin
      idex_wr_pxl_d     = ifid_q[25];
      idex_wr_pos_d     = ifid_q[24];
      idex_wr_mul_reg_d = ifid_q[23];
      idex_wr_mul_pos_d = ifid_q[22];
      idex_wr_wom_d     = ifid_q[21];
      idex_alu_func_d   = (id_op == OP_VMUL);
      idex_pix_d        = p_q[ifid_q[27]];
      idex_cte_d        = m_q[ifid_q[26]];
      idex_addr_d       = i_q * n_q + j_q;
    end

    // SETI writes the scalar file directly from ID; ssel=3 is a no-op.
    i_d = i_q;
    j_d = j_q;
    n_d = n_q;
    if (id_is_seti) begin
      case (id_ssel)
        2'd0:    i_d = id_imm;
        2'd1:    j_d = id_imm;
        2'd2:    n_d = id_imm;
        default: ;
      endcase
    end

    // ---------------- EX ----------------
    for (int k = 0; k < 4; k++) begin
      exmem_r_d[k] = idex_alu_func_q ? (idex_pix_q[k] * idex_cte_q[k])
                                     : (idex_pix_q[k] + idex_cte_q[k]);
    end
    exmem_wr_pxl_d     = idex_wr_pxl_q;
    exmem_wr_pos_d     = idex_wr_pos_q;
    exmem_wr_mul_reg_d = idex_wr_mul_reg_q;
    exmem_wr_mul_pos_d = idex_wr_mul_pos_q;
    exmem_wr_wom_d     = idex_wr_wom_q;
    exmem_addr_d       = idex_addr_q;

    // ---------------- MEM ----------------
    // Load samples the pre-edge contents, so a same-edge store is not seen.
    memwb_load_d = wom_q[exmem_addr_q[3:0]];
    wom_d        = wom_q;
    if (exmem_wr_wom_q) wom_d[exmem_addr_q[3:0]] = exmem_r_q;

    // Internal write-back first, external write second: the external one
    // wins when both hit the same entry on the same edge.
    p_d = p_q;
    if (exmem_wr_pxl_q) p_d[exmem_wr_pos_q] = exmem_r_q;
    if (we_pxl)         p_d[wr_pos_pxl]     = wdp_v;

    m_d = m_q;
    if (exmem_wr_mul_reg_q) m_d[exmem_wr_mul_pos_q] = exmem_r_q;
    if (we_mul)             m_d[wr_mul_pos_in]      = wdm_v;
  end

`ifdef SUMR_ACC_EN
  always_comb begin
    idex_vec_d  = id_is_vec;
    exmem_vec_d = idex_vec_q;
    sumr_d      = sumr_q;
    if (exmem_vec_q) begin
      for (int k = 0; k < 4; k++) sumr_d[k] = sumr_q[k] + exmem_r_q[k];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q               <= '0;
      ifid_q             <= '0;
      i_q                <= '0;
      j_q                <= '0;
      n_q                <= '0;
      for (int e = 0; e < 2; e++) begin
        p_q[e] <= '0;
        m_q[e] <= '0;
      end
      for (int e = 0; e < 16; e++) wom_q[e] <= '0;
      idex_wr_pxl_q      <= 1'b0;
      idex_wr_pos_q      <= 1'b0;
      idex_wr_mul_reg_q  <= 1'b0;
      idex_wr_mul_pos_q  <= 1'b0;
      idex_wr_wom_q      <= 1'b0;
      idex_alu_func_q    <= 1'b0;
      idex_pix_q         <= '0;
      idex_cte_q         <= '0;
      idex_addr_q        <= '0;
      exmem_wr_pxl_q     <= 1'b0;
      exmem_wr_pos_q     <= 1'b0;
      exmem_wr_mul_reg_q <= 1'b0;
      exmem_wr_mul_pos_q <= 1'b0;
      exmem_wr_wom_q     <= 1'b0;
      exmem_r_q          <= '0;
      exmem_addr_q       <= '0;
      memwb_load_q       <= '0;
    end else begin
      pc_q               <= pc_d;
      ifid_q             <= ifid_d;
      i_q                <= i_d;
      j_q                <= j_d;
      n_q                <= n_d;
      p_q                <= p_d;
      m_q                <= m_d;
      wom_q              <= wom_d;
      idex_wr_pxl_q      <= idex_wr_pxl_d;
      idex_wr_pos_q      <= idex_wr_pos_d;
      idex_wr_mul_reg_q  <= idex_wr_mul_reg_d;
      idex_wr_mul_pos_q  <= idex_wr_mul_pos_d;
      idex_wr_wom_q      <= idex_wr_wom_d;
      idex_alu_func_q    <= idex_alu_func_d;
      idex_pix_q         <= idex_pix_d;
      idex_cte_q         <= idex_cte_d;
      idex_addr_q        <= idex_addr_d;
      exmem_wr_pxl_q     <= exmem_wr_pxl_d;
      exmem_wr_pos_q     <= exmem_wr_pos_d;
      exmem_wr_mul_reg_q <= exmem_wr_mul_reg_d;
      exmem_wr_mul_pos_q <= exmem_wr_mul_pos_d;
      exmem_wr_wom_q     <= exmem_wr_wom_d;
      exmem_r_q          <= exmem_r_d;
      exmem_addr_q       <= exmem_addr_d;
      memwb_load_q       <= memwb_load_d;
    end
  end

`ifdef SUMR_ACC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_vec_q  <= 1'b0;
      exmem_vec_q <= 1'b0;
      sumr_q      <= '0;
    end else begin
      idex_vec_q  <= idex_vec_d;
      exmem_vec_q <= exmem_vec_d;
      sumr_q      <= sumr_d;
    end
  end

  assign sumr1 = sumr_q[0];
  assign sumr2 = sumr_q[1];
  assign sumr3 = sumr_q[2];
  assign sumr4 = sumr_q[3];
`else
  assign sumr1 = '0;
  assign sumr2 = '0;
  assign sumr3 = '0;
  assign sumr4 = '0;
`endif

  // Only the low 4 address bits index WOM; bits [20:16] of the word are
  // reserved in every format.
  logic unused_bits;
  assign unused_bits = ^{exmem_addr_q[31:4], ifid_q[20:16]};

  // Output mapping
  assign instr_out      = ifid_q;
  assign wr_pxl         = idex_wr_pxl_q;
  assign wr_pos         = idex_wr_pos_q;
  assign wr_mul_reg     = idex_wr_mul_reg_q;
  assign alu_func       = idex_alu_func_q;
  assign wr_wom         = idex_wr_wom_q;
  assign wr_mul_pos_out = idex_wr_mul_pos_q;
  assign pix_out1       = idex_pix_q[0];
  assign pix_out2       = idex_pix_q[1];
  assign pix_out3       = idex_pix_q[2];
  assign pix_out4       = idex_pix_q[3];
  assign cte_out1       = idex_cte_q[0];
  assign cte_out2       = idex_cte_q[1];
  assign cte_out3       = idex_cte_q[2];
  assign cte_out4       = idex_cte_q[3];
  assign wom_addr       = idex_addr_q;
  assign mul_out1       = m_q[0][0];
  assign mul_out2       = m_q[0][1];
  assign mul_out3       = m_q[0][2];
  assign mul_out4       = m_q[0][3];
  assign mul_out5       = m_q[1][0];
  assign mul_out6       = m_q[1][1];
  assign mul_out7       = m_q[1][2];
  assign mul_out8       = m_q[1][3];
  assign i              = i_q;
  assign j              = j_q;
  assign n              = n_q;
  assign r1             = exmem_r_q[0];
  assign r2             = exmem_r_q[1];
  assign r3             = exmem_r_q[2];
  assign r4             = exmem_r_q[3];
  assign load1          = memwb_load_q[0];
  assign load2          = memwb_load_q[1];
  assign load3          = memwb_load_q[2];
  assign load4          = memwb_load_q[3];

endmodule

// File: tb/tb_vector_cpu_ifidexemem_core.sv
// ---------------------------------------------------------------------------
// Testbench for vector_cpu_ifidexemem_core.
// A fixed program is loaded through ROM_IMAGE. An instruction-level model
// computes each instruction's results; those are pushed into a scoreboard
// tagged with the clock edge at which the pipeline must present them, and
// popped/compared on the falling edge after that clock edge.
// ---------------------------------------------------------------------------
module tb_vector_cpu_ifidexemem_core;

  // ---------------- program ----------------
  localparam logic [1023:0] ROM_IMAGE = {
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,        // 31..24
    32'h0, 32'h0, 32'h0, 32'h0,                                    // 23..20
    32'h10000000,  // 19 VADD P0,M0 (sees collision result)
    32'h0, 32'h0,  // 18,17
    32'h12000000,  // 16 VADD P0,M0 -> P[0]
    32'h1C000000,  // 15 VADD P1,M1
    32'h0, 32'h0,  // 14,13
    32'h13C00000,  // 12 VADD -> P[1], M[1]
    32'h10200000,  // 11 VADD -> WOM
    32'h20000000,  // 10 VMUL
    32'h10200000,  //  9 VADD -> WOM
    32'h0,         //  8
    32'h330000FF,  //  7 SETI ssel=3 (no effect)
    32'h3200000A,  //  6 SETI n=10
    32'h31000003,  //  5 SETI j=3
    32'h30000002,  //  4 SETI i=2
    32'h0, 32'h0, 32'h0, 32'h0                                     //  3..0
  };

  localparam int RUN_EDGES = 24;
  localparam int COLL_K    = 16;

  localparam logic [127:0] M0_INIT = {32'h00010000, 32'd5, 32'd1, 32'h416D5267};
  localparam logic [127:0] M1_EXT  = {32'h426D5267, 96'h0};
  localparam logic [127:0] P0_INIT = {32'h00010000, 32'd3, 32'hFFFFFFFF, 32'h416D5267};
  localparam logic [127:0] X_VEC   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wr_pos_pxl, we_pxl, we_mul, wr_mul_pos_in;
  logic [31:0] wdp1, wdp2, wdp3, wdp4, wdm1, wdm2, wdm3, wdm4;
  logic [31:0] instr_out;
  logic        wr_pxl, wr_pos, wr_mul_reg, alu_func, wr_wom, wr_mul_pos_out;
  logic [31:0] pix_out1, pix_out2, pix_out3, pix_out4;
  logic [31:0] cte_out1, cte_out2, cte_out3, cte_out4;
  logic [31:0] mul_out1, mul_out2, mul_out3, mul_out4;
  logic [31:0] mul_out5, mul_out6, mul_out7, mul_out8;
  logic [31:0] i, j, n, wom_addr;
  logic [31:0] r1, r2, r3, r4, load1, load2, load3, load4;
  logic [31:0] sumr1, sumr2, sumr3, sumr4;

  vector_cpu_ifidexemem_core #(.ROM_IMAGE(ROM_IMAGE)) u_dut (
    .clk(clk), .rst(rst),
    .wr_pos_pxl(wr_pos_pxl), .we_pxl(we_pxl), .we_mul(we_mul),
    .wdp1(wdp1), .wdp2(wdp2), .wdp3(wdp3), .wdp4(wdp4),
    .wdm1(wdm1), .wdm2(wdm2), .wdm3(wdm3), .wdm4(wdm4),
    .wr_mul_pos_in(wr_mul_pos_in),
    .instr_out(instr_out),
    .wr_pxl(wr_pxl), .wr_pos(wr_pos), .wr_mul_reg(wr_mul_reg),
    .alu_func(alu_func), .wr_wom(wr_wom), .wr_mul_pos_out(wr_mul_pos_out),
    .pix_out1(pix_out1), .pix_out2(pix_out2), .pix_out3(pix_out3), .pix_out4(pix_out4),
    .cte_out1(cte_out1), .cte_out2(cte_out2), .cte_out3(cte_out3), .cte_out4(cte_out4),
    .mul_out1(mul_out1), .mul_out2(mul_out2), .mul_out3(mul_out3), .mul_out4(mul_out4),
    .mul_out5(mul_out5), .mul_out6(mul_out6), .mul_out7(mul_out7), .mul_out8(mul_out8),
    .i(i), .j(j), .n(n), .wom_addr(wom_addr),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .load1(load1), .load2(load2), .load3(load3), .load4(load4),
    .sumr1(sumr1), .sumr2(sumr2), .sumr3(sumr3), .sumr4(sumr4)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  int           exp_edge_q[$];
  int           exp_kind_q[$];

  task automatic push_exp(input int e, input int kind, input logic [127:0] v);
    exp_q.push_back(v);
    exp_edge_q.push_back(e);
    exp_kind_q.push_back(kind);
  endtask

  function automatic string kind_name(input int kind);
    case (kind)
      0:  return "instr_out";
      1:  return "idex_ctrl";
      2:  return "wom_addr";
      3:  return "pix_out";
      4:  return "ijn";
      5:  return "r";
      6:  return "load";
      7:  return "sumr";
      8:  return "mul_out_hi";
      9:  return "mul_out1";
      10: return "mul_out8";
      11: return "mul_out_lo";
      12: return "cte_out";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [127:0] observe(input int kind);
    case (kind)
      0:  return {96'h0, instr_out};
      1:  return {122'h0, wr_pxl, wr_pos, wr_mul_reg, alu_func, wr_wom, wr_mul_pos_out};
      2:  return {96'h0, wom_addr};
      3:  return {pix_out4, pix_out3, pix_out2, pix_out1};
      4:  return {32'h0, i, j, n};
      5:  return {r4, r3, r2, r1};
      6:  return {load4, load3, load2, load1};
      7:  return {sumr4, sumr3, sumr2, sumr1};
      8:  return {mul_out8, mul_out7, mul_out6, mul_out5};
      9:  return {96'h0, mul_out1};
      10: return {96'h0, mul_out8};
      11: return {mul_out4, mul_out3, mul_out2, mul_out1};
      12: return {cte_out4, cte_out3, cte_out2, cte_out1};
      default: return '1;
    endcase
  endfunction

  task automatic compare_edge(input int e);
    while (exp_edge_q.size() > 0 && exp_edge_q[0] == e) begin
      logic [127:0] v;
      int           kind;
      v    = exp_q.pop_front();
      kind = exp_kind_q.pop_front();
      void'(exp_edge_q.pop_front());
      check(kind_name(kind), observe(kind), v);
    end
  endtask

  // ---------------- instruction-level model ----------------
  logic [127:0] e_ctrl [32];
  logic [127:0] e_addr [32];
  logic [127:0] e_pix  [32];
  logic [127:0] e_cte  [32];
  logic [127:0] e_r    [32];
  logic [127:0] e_load [32];
  logic [127:0] e_sumr [32];
  logic [127:0] e_mul  [32];
  logic [127:0] e_ijn  [32];
  bit           is_v   [32];
  bit           is_s   [32];

  function automatic logic [31:0] rom_word(input int k);
    return ROM_IMAGE[(k % 32) * 32 +: 32];
  endfunction

  task automatic build_model();
    logic [127:0] mp [2];
    logic [127:0] mm [2];
    logic [127:0] wom [16];
    logic [127:0] sumr, pix, cte, r;
    logic [31:0]  si, sj, sn, w, a, b, addr;
    logic [3:0]   op;
    mp[0] = P0_INIT; mp[1] = '0;
    mm[0] = M0_INIT; mm[1] = M1_EXT;
    for (int e = 0; e < 16; e++) wom[e] = '0;
    sumr = '0; si = 0; sj = 0; sn = 0;
    for (int k = 0; k < 32; k++) begin
      w  = rom_word(k);
      op = w[31:28];
      is_v[k] = (op == 4'd1) || (op == 4'd2);
      is_s[k] = (op == 4'd3);
      e_ctrl[k] = '0;
      if (is_s[k]) begin
        if (w[25:24] == 2'd0) si = {16'h0, w[15:0]};
        if (w[25:24] == 2'd1) sj = {16'h0, w[15:0]};
        if (w[25:24] == 2'd2) sn = {16'h0, w[15:0]};
        e_ijn[k] = {32'h0, si, sj, sn};
      end
      if (is_v[k]) begin
        e_ctrl[k] = {122'h0, w[25], w[24], w[23], op == 4'd2, w[21], w[22]};
        pix  = mp[w[27]];
        cte  = mm[w[26]];
        addr = si * sn + sj;
        for (int l = 0; l < 4; l++) begin
          a = pix[l*32 +: 32];
          b = cte[l*32 +: 32];
          r[l*32 +: 32] = (op == 4'd2) ? a * b : a + b;
        end
        e_pix[k]  = pix;
        e_cte[k]  = cte;
        e_addr[k] = {96'h0, addr};
        e_r[k]    = r;
        e_load[k] = wom[addr[3:0]];
        if (w[21]) wom[addr[3:0]] = r;
        if (w[25]) mp[w[24]] = r;
        if (w[23]) mm[w[22]] = r;
        e_mul[k] = mm[w[22]];
`ifdef SUMR_ACC_EN
        for (int l = 0; l < 4; l++) sumr[l*32 +: 32] = sumr[l*32 +: 32] + r[l*32 +: 32];
`endif
        e_sumr[k] = sumr;
      end
      // External write lands on the same edge as this instruction's write-back.
      if (k == COLL_K) mp[0] = X_VEC;
    end
  endtask

  task automatic fill_scoreboard();
    int k;
    for (int e = 1; e <= RUN_EDGES; e++) begin
      push_exp(e, 0, {96'h0, rom_word(e - 1)});
      if (e == 1) push_exp(e, 9, {96'h0, M0_INIT[31:0]});
      if (e == 2) begin
        push_exp(e, 10, {96'h0, M1_EXT[127:96]});
        push_exp(e, 9, {96'h0, M0_INIT[31:0]});
      end
      k = e - 2;
      if (k >= 0) begin
        push_exp(e, 1, e_ctrl[k]);
        if (is_v[k]) begin
          push_exp(e, 2, e_addr[k]);
          push_exp(e, 3, e_pix[k]);
          push_exp(e, 12, e_cte[k]);
        end
        if (is_s[k]) push_exp(e, 4, e_ijn[k]);
      end
      k = e - 3;
      if (k >= 0 && is_v[k]) push_exp(e, 5, e_r[k]);
      k = e - 4;
      if (k >= 0 && is_v[k]) begin
        push_exp(e, 6, e_load[k]);
        push_exp(e, 7, e_sumr[k]);
        if (rom_word(k)[23]) push_exp(e, rom_word(k)[22] ? 8 : 11, e_mul[k]);
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    we_pxl = 1'b0; we_mul = 1'b0; wr_pos_pxl = 1'b0; wr_mul_pos_in = 1'b0;
    {wdp4, wdp3, wdp2, wdp1} = '0;
    {wdm4, wdm3, wdm2, wdm1} = '0;
  endtask

  // Sets up the external write that happens at clock edge e.
  task automatic drive_edge(input int e, input bit with_collision);
    drive_idle();
    if (e == 1) begin
      we_mul = 1'b1; wr_mul_pos_in = 1'b0; {wdm4, wdm3, wdm2, wdm1} = M0_INIT;
    end else if (e == 2) begin
      we_mul = 1'b1; wr_mul_pos_in = 1'b1; {wdm4, wdm3, wdm2, wdm1} = M1_EXT;
    end else if (e == 3) begin
      we_pxl = 1'b1; wr_pos_pxl = 1'b0; {wdp4, wdp3, wdp2, wdp1} = P0_INIT;
    end else if (with_collision && e == COLL_K + 4) begin
      we_pxl = 1'b1; wr_pos_pxl = 1'b0; {wdp4, wdp3, wdp2, wdp1} = X_VEC;
    end
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, "_instr"}, {96'h0, instr_out}, '0);
    check({pfx, "_ctrl"}, observe(1), '0);
    check({pfx, "_r"}, observe(5), '0);
    check({pfx, "_load"}, observe(6), '0);
    check({pfx, "_sumr"}, observe(7), '0);
    check({pfx, "_mul_lo"}, observe(11), '0);
    check({pfx, "_mul_hi"}, observe(8), '0);
    check({pfx, "_ijn"}, observe(4), '0);
    check({pfx, "_wom_addr"}, observe(2), '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks("rst0");

    build_model();
    fill_scoreboard();
    rst = 1'b0;
    for (int e = 1; e <= RUN_EDGES; e++) begin
      drive_edge(e, 1'b1);
      @(posedge clk);
      @(negedge clk);
      compare_edge(e);
    end
    check("sb_drain", exp_q.size(), 0);

    // Second pass: reset in the middle of the program with vector ops in flight.
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      drive_edge(e, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_i_before_rst", {96'h0, i}, 128'd2);
    drive_idle();
    #2 rst = 1'b1;
    #1 reset_checks("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      @(negedge clk);
      check("restart_instr", {96'h0, instr_out}, {96'h0, rom_word(e - 1)});
      check("restart_mul_hi", observe(8), '0);
    end
    check("restart_r", observe(5), '0);
    check("restart_load", observe(6), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vector_cpu_ifidexemem_core.md
VECTOR_CPU_IFIDEXEMEM_CORE -- requirements
Module: vector_cpu_IFIDEXEMEM

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 clock (rising edge); rst input 1 asynchronous active-high reset.
REQ-002 Inputs SHALL be: wr_pos_pxl 1 (pixel-bank entry); we_pxl 1 (pixel-bank write enable); we_mul 1 (mul-bank write enable); wdp1..wdp4 32 each (pixel lane data); wdm1..wdm4 32 each (mul lane data); wr_mul_pos_in 1 (mul-bank entry).
REQ-003 Outputs SHALL be: instr_out 32 (IF/ID instruction); wr_pxl, wr_pos, wr_mul_reg, alu_func, wr_wom, wr_mul_pos_out 1 each (ID/EX controls); pix_out1..4, cte_out1..4 32 each (ID/EX operands); mul_out1..8 32 each (mul bank); i, j, n 32 each (scalar regs); wom_addr 32 (ID/EX store address).
REQ-004 Outputs r1..r4 32 each (EX/MEM ALU result) and load1..4, sumr1..4 32 each (MEM/WB) SHALL also be provided.

Function
REQ-005 Storage SHALL comprise: pixel bank P[0..1] and mul bank M[0..1], each entry 4 lanes x 32 bits; scalar registers i, j, n; output memory WOM, 16 entries x 4 lanes x 32 bits; 32-word instruction ROM initialised from vector_prog.hex, with unlisted words = 0 (NOP).
REQ-006 External write SHALL occur at the clock edge: we_pxl=1 -> P[wr_pos_pxl] <= {wdp1..4}; we_mul=1 -> M[wr_mul_pos_in] <= {wdm1..4}.
REQ-007 mul_out1..4 SHALL equal M[0] lanes 1..4 and mul_out5..8 SHALL equal M[1] lanes 1..4, continuously.
REQ-008 The PC SHALL be 5 bits, increment every cycle and wrap 31->0, with no stalls and no branches; IF/ID <= ROM[PC].
REQ-009 Instruction fields SHALL be: op [31:28]; psel [27]; msel [26]; wr_pxl [25]; wr_pos [24]; wr_mul_reg [23]; wr_mul_pos [22]; wr_wom [21]; ssel [25:24]; imm [15:0].
REQ-010 Opcodes SHALL be: 0 NOP; 1 VADD; 2 VMUL; 3 SETI; 4..15 treated as NOP. NOP, SETI and illegal opcodes SHALL drive all ID/EX controls to 0.
REQ-011 SETI in ID SHALL set, at that edge, i (ssel=0), j (ssel=1) or n (ssel=2) to zero-extended imm; ssel=3 SHALL have no effect.
REQ-012 For VADD/VMUL, ID/EX SHALL latch pix = P[psel], cte = M[msel], the control bits, alu_func (1 = VMUL), and wom_addr = low 32 bits of i*n+j using current register values.
REQ-013 EXE SHALL compute, per lane k: r_k = alu_func ? low 32 bits of pix_k*cte_k : pix_k+cte_k (unsigned, wrapping), latched into EX/MEM with the controls and address.
REQ-014 MEM SHALL perform, at the edge and by EX/MEM controls: wr_wom -> WOM[wom_addr[3:0]] <= r; wr_pxl -> P[wr_pos] <= r; wr_mul_reg -> M[wr_mul_pos] <= r.
REQ-015 MEM SHALL also latch load = WOM[wom_addr[3:0]], read before the same-edge write, into MEM/WB.
REQ-016 An external write and an internal write-back to the same bank entry at the same edge SHALL resolve with the external write winning.
REQ-017 There SHALL be no forwarding: ID reads return pre-edge contents, and software inserts 2 NOPs between dependent instructions.
REQ-018 Latency SHALL be: ROM[k] appears on instr_out at edge k+1 after reset release, ID/EX outputs at k+2, r at k+3, and load/sumr/write-backs at k+4.

Reset
REQ-019 rst SHALL asynchronously clear PC, all pipeline registers (NOP, every output 0), i, j, n, P, M, WOM and sumr; ROM is unaffected.
REQ-020 Reset asserted mid-program SHALL abort in-flight instructions without performing their writes; after release, fetch SHALL restart at ROM[0].

Configuration
REQ-021 With SUMR_ACC_EN defined, every VADD/VMUL reaching MEM SHALL update sumr_k <= sumr_k + r_k (wrapping); without SUMR_ACC_EN, sumr1..4 SHALL be constant 0 and no accumulator logic SHALL exist.

Verification
REQ-022 Reset: rst=1 -> instr_out, all controls, r, load, sumr, mul_out and i/j/n = 0; after release, instr_out = ROM[0] on the 1st edge.
REQ-023 Bank load: we_mul=1, pos 0, wdm1=0x416D5267 -> mul_out1=0x416D5267 next edge; pos 1, wdm4=0x426D5267 -> mul_out8=0x426D5267; mul_out1 unchanged.
REQ-024 VADD: P0.lane1=0x416D5267, M0.lane1=0x416D5267, ROM[0]=0x10000000 -> r1=0x82DAA4CE at edge 3; lane 0xFFFFFFFF+1 -> 0.
REQ-025 VMUL: ROM[0]=0x20000000, lanes 3 and 5 -> r=15 at edge 3; 0x10000*0x10000 -> 0.
REQ-026 Store/load: SETI i=2, j=3, n=10, 2 NOPs, VADD with wr_wom -> wom_addr=23, WOM[7]=r; a later identical VADD -> load = first r; with SUMR_ACC_EN, sumr = 2r.
REQ-027 Collision: internal write-back to P[0] at the same edge as we_pxl=1, pos 0 -> P[0] holds the external data.
